// File: rtl/multidigit_code_converter.sv
// Multi-digit BCD <-> Excess-3 converter.
// A request captures the whole input word, then one 4-bit digit is converted
// per clock, least-significant digit first. Digits outside the legal range of
// the selected source code pass through unchanged and are flagged in err_mask.
//
// Handshake: start is sampled only while busy=0. The rising edge that samples
// start=1 in IDLE is edge 0. Digit k is converted at edge k+1. done is high for
// exactly one cycle, between edge DIGITS and edge DIGITS+1. dout, err_mask and
// err are valid from that done cycle and hold until the next accepted start.
module multidigit_code_converter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   dout,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   din_q, din_d;
  logic                  mode_q, mode_d;
  logic [4*DIGITS-1:0]   dout_q, dout_d;
  logic [DIGITS-1:0]     err_mask_q, err_mask_d;
  logic                  err_q, err_d;

  logic [3:0]            cur_digit;
  logic [3:0]            conv_digit;
  logic                  conv_bad;

  // Convert the digit currently selected by the index in the latched word.
  always_comb begin
    cur_digit  = din_q[4*int'(idx_q) +: 4];
    conv_digit = cur_digit;
    conv_bad   = 1'b0;
    if (!mode_q) begin
      // BCD -> Excess-3: only 0..9 are legal BCD digits.
      if (cur_digit <= 4'd9) begin
        conv_digit = cur_digit + 4'd3;
      end else begin
        conv_bad = 1'b1;
      end
    end else begin
      // Excess-3 -> BCD: only 3..12 are legal Excess-3 digits.
      if (cur_digit >= 4'd3 && cur_digit <= 4'd12) begin
        conv_digit = cur_digit - 4'd3;
      end else begin
        conv_bad = 1'b1;
      end
    end
  end

  // Next-state and datapath update for the IDLE/CONV/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    din_d      = din_q;
    mode_d     = mode_q;
    dout_d     = dout_q;
    err_mask_d = err_mask_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          din_d      = din;
          mode_d     = mode;
          dout_d     = '0;
          err_mask_d = '0;
          err_d      = 1'b0;
          idx_d      = '0;
          state_d    = CONV;
        end
      end
      CONV: begin
        dout_d[4*int'(idx_q) +: 4] = conv_digit;
        err_mask_d[idx_q]          = conv_bad;
        if (idx_q == LAST_IDX) begin
          // err must already be correct in the done cycle, so it is folded
          // from the completed mask on the edge that enters DONE.
          idx_d   = '0;
          err_d   = |err_mask_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        err_d   = |err_mask_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      din_q      <= '0;
      mode_q     <= 1'b0;
      dout_q     <= '0;
      err_mask_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      din_q      <= din_d;
      mode_q     <= mode_d;
      dout_q     <= dout_d;
      err_mask_q <= err_mask_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign dout     = dout_q;
  assign err_mask = err_mask_q;
  assign err      = err_q;

endmodule

// File: tb/tb_multidigit_code_converter.sv
// Testbench for multidigit_code_converter (DIGITS=4).
// Stimulus pushes {expected done cycle, dout, err_mask, err} into exp_q; a
// monitor branch pops and compares whenever done is seen.
module tb_multidigit_code_converter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int RW     = W + DIGITS + 1;
  localparam int EW     = 32 + RW;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mode;
  logic [W-1:0]      din;
  logic              busy;
  logic              done;
  logic [W-1:0]      dout;
  logic [DIGITS-1:0] err_mask;
  logic              err;

  int cyc;
  int errors;
  int checks;
  logic [EW-1:0] exp_q[$];

  multidigit_code_converter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .err_mask (err_mask),
    .err      (err)
  );

  // Clock and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: per-digit code rules written directly with integer arithmetic.
  function automatic logic [RW-1:0] model(input logic m, input logic [W-1:0] d);
    logic [W-1:0]      o;
    logic [DIGITS-1:0] msk;
    int                v;
    o   = '0;
    msk = '0;
    for (int k = 0; k < DIGITS; k++) begin
      v = int'(d[4*k +: 4]);
      if (m == 1'b0) begin
        if (v <= 9) o[4*k +: 4] = 4'(v + 3);
        else begin o[4*k +: 4] = 4'(v); msk[k] = 1'b1; end
      end else begin
        if (v >= 3 && v <= 12) o[4*k +: 4] = 4'(v - 3);
        else begin o[4*k +: 4] = 4'(v); msk[k] = 1'b1; end
      end
    end
    return {o, msk, |msk};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one request; c0 is the count of the start-sampling edge (edge 0).
  task automatic launch(input logic m, input logic [W-1:0] d, input logic [RW-1:0] expv,
                        input bit hold, output int c0);
    wait_idle();
    mode  = m;
    din   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    exp_q.push_back({32'(c0 + DIGITS), expv});
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_err_mask"}, 32'(err_mask), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [EW-1:0] e;
    logic [RW-1:0] r;
    int c0, prev;
    logic m;
    logic [W-1:0] d;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    din    = '0;
    fork
      // Monitor: compare each done pulse against the oldest expectation.
      begin
        forever begin
          @(negedge clk);
          if (done) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              r = e[RW-1:0];
              chk("done_cycle", 32'(cyc), e[EW-1 -: 32]);
              chk("dout", 32'(dout), 32'(r[RW-1 -: W]));
              chk("err_mask", 32'(err_mask), 32'(r[DIGITS:1]));
              chk("err", 32'(err), 32'(r[0]));
              chk("busy_in_done", 32'(busy), 32'd1);
            end
          end
        end
      end
      // Stimulus.
      begin
        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        launch(1'b0, 16'h1209, {16'h453C, 4'b0000, 1'b0}, 1'b0, c0);
        launch(1'b1, 16'h453C, {16'h1209, 4'b0000, 1'b0}, 1'b0, c0);
        launch(1'b0, 16'h0A93, {16'h3AC6, 4'b0100, 1'b1}, 1'b0, c0);
        launch(1'b1, 16'h0F33, {16'h0F00, 4'b1100, 1'b1}, 1'b0, c0);
        launch(1'b0, 16'h9999, {16'hCCCC, 4'b0000, 1'b0}, 1'b0, c0);
        launch(1'b1, 16'hCCCC, {16'h9999, 4'b0000, 1'b0}, 1'b0, c0);
        drain();

        // Re-pulse start at edge 2 with different inputs: must be ignored.
        launch(1'b0, 16'h1209, {16'h453C, 4'b0000, 1'b0}, 1'b0, c0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        din   = 16'h7777;
        mode  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // Reset after edge 2 aborts the conversion with no done pulse.
        launch(1'b0, 16'h5678, {16'h89AB, 4'b0000, 1'b0}, 1'b0, c0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_all_zero("abort");
        repeat (2) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        launch(1'b0, 16'h0000, {16'h3333, 4'b0000, 1'b0}, 1'b0, c0);
        drain();

        // Start held high: one acceptance per IDLE cycle.
        prev = 0;
        for (int i = 0; i < 6; i++) begin
          m = 1'($urandom_range(0, 1));
          d = 16'($urandom);
          launch(m, d, model(m, d), 1'b1, c0);
          if (i > 0) chk("b2b_period", 32'(c0 - prev), 32'(DIGITS + 2));
          prev = c0;
        end
        start = 1'b0;
        drain();

        // Random requests with gaps.
        for (int i = 0; i < 40; i++) begin
          m = 1'($urandom_range(0, 1));
          d = 16'($urandom);
          launch(m, d, model(m, d), 1'b0, c0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        repeat (4) @(negedge clk);
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multidigit_code_converter.md
MULTIDIGIT_CODE_CONVERTER -- requirements
Module: multidigit_code_converter

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of 4-bit code digits per word; legal range 1..16.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL be the request strobe; sampled only when busy=0.
REQ-005 mode  input  1  SHALL select the direction: 0 = BCD to Excess-3, 1 = Excess-3 to BCD.
REQ-006 din  input  4*DIGITS  SHALL carry the packed input word; digit k = din[4k+3:4k].
REQ-007 busy  output  1  SHALL be high while a conversion is in progress, CONV or DONE.
REQ-008 done  output  1  SHALL be a one-cycle completion pulse.
REQ-009 dout  output  4*DIGITS  SHALL carry the packed converted word; digit k = dout[4k+3:4k].
REQ-010 err_mask  output  DIGITS  SHALL flag invalid digits; bit k = 1 means digit k was invalid.
REQ-011 err  output  1  SHALL be the OR of err_mask.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-013 IDLE with start=1 at a rising edge SHALL cause the following in that edge: latch din and mode internally; clear dout, err_mask and err to 0; set digit index to 0; go to CONV.
REQ-014 In CONV, each rising edge SHALL convert digit[index], write the result into dout digit[index], and write err_mask[index].
REQ-015 In CONV, each rising edge SHALL increment index; the edge that converts digit DIGITS-1 SHALL move the FSM to DONE.
REQ-016 Digits SHALL be processed LSB-first, one per clock.
REQ-017 Total latency: with the start-sampling edge counted as edge 0, done SHALL be high in exactly the cycle between edge DIGITS and edge DIGITS+1.
REQ-018 In DONE, the FSM SHALL update err to the OR of err_mask, assert done, and return to IDLE at the next edge.
REQ-019 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1, and neither din nor mode changes SHALL affect a conversion in progress.
REQ-021 Mode 0, digit d<=9: result SHALL be d+3, 4-bit.
REQ-022 Mode 0, digit d>=10: result SHALL be d passed through unchanged, with the err_mask bit set.
REQ-023 Mode 1, digit 3<=d<=12: result SHALL be d-3.
REQ-024 Mode 1, digit d<3 or d>12: result SHALL be d passed through unchanged, with the err_mask bit set.
REQ-025 dout, err_mask and err SHALL be valid from the done cycle onward and hold until the next accepted start.
REQ-026 dout and err_mask contents during CONV are partial and SHALL NOT be relied upon by consumers.
REQ-027 start held high continuously SHALL produce back-to-back conversions: one start accepted in each IDLE cycle, giving a period of DIGITS+2 cycles.
REQ-028 DIGITS=1 SHALL give CONV one cycle long, with done high during the cycle following edge 1.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force: state to IDLE; index, busy, done, err, err_mask and dout to 0; internal latches to 0.
REQ-030 rst asserted mid-conversion SHALL abort it, and no done pulse SHALL be produced for the aborted request.
REQ-031 After rst deasserts, the first start sampled in IDLE SHALL begin a normal conversion.

Verification (DIGITS=4)
REQ-032 Mode 0, din=16'h1209, start pulse -> dout=16'h453C, err_mask=4'b0000, err=0, done only between edges 4 and 5.
REQ-033 Mode 1, din=16'h453C -> dout=16'h1209, err=0.
REQ-034 Mode 0, din=16'h0A93 -> dout=16'h3AC6, err_mask=4'b0100, err=1.
REQ-035 Mode 1, din=16'h0F33 -> dout=16'h0F00, err_mask=4'b1100, err=1.
REQ-036 Boundaries: mode 0, din=16'h9999 -> dout=16'hCCCC; mode 1, din=16'hCCCC -> dout=16'h9999; both with err=0.
REQ-037 Mode 0, start re-pulsed at edge 2 with a different din -> original result delivered and second start ignored.
REQ-038 rst asserted after edge 2 -> all outputs 0, no done; then a fresh start with din=16'h0000, mode 0 -> dout=16'h3333.
